// File: rtl/kb_tone_pkg.sv
// Shared scan-code constants, phase-increment table and scheduler FSM encoding
// for the PS/2 keyboard tone path.
package kb_tone_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_NOTE0 = 8'h1C;
  localparam logic [7:0] SC_NOTE1 = 8'h1B;
  localparam logic [7:0] SC_NOTE2 = 8'h23;
  localparam logic [7:0] SC_NOTE3 = 8'h2B;
  localparam logic [7:0] SC_NOTE4 = 8'h34;
  localparam logic [7:0] SC_NOTE5 = 8'h33;
  localparam logic [7:0] SC_NOTE6 = 8'h3B;
  localparam logic [7:0] SC_NOTE7 = 8'h42;

  // round(f * 65536 / 48000) for each note index
  localparam logic [15:0] PHASE_INC [0:7] = '{
    16'd714, 16'd802, 16'd900, 16'd954, 16'd1070, 16'd1201, 16'd1349, 16'd1429
  };

  typedef enum logic [1:0] {StIdle, StAck, StProc} state_e;

endpackage

// File: rtl/ps2_scan_decode.sv
// Combinational map from a scan byte to a musical note index.
module ps2_scan_decode
  import kb_tone_pkg::*;
(
  input  logic [7:0] code_i,
  output logic       is_note_o,
  output logic [2:0] note_idx_o
);

  always_comb begin
    is_note_o  = 1'b1;
    note_idx_o = 3'd0;
    case (code_i)
      SC_NOTE0: note_idx_o = 3'd0;
      SC_NOTE1: note_idx_o = 3'd1;
      SC_NOTE2: note_idx_o = 3'd2;
      SC_NOTE3: note_idx_o = 3'd3;
      SC_NOTE4: note_idx_o = 3'd4;
      SC_NOTE5: note_idx_o = 3'd5;
      SC_NOTE6: note_idx_o = 3'd6;
      SC_NOTE7: note_idx_o = 3'd7;
      default:  is_note_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_voice_scheduler.sv
// Drains the PS/2 scan-code FIFO one byte per three cycles and allocates held
// musical keys to polyphonic voice slots, stealing round-robin when full.
module ps2_voice_scheduler
  import kb_tone_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned INC_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        kb_data,
  input  logic                              kb_ready,
  input  logic                              kb_overflow,
  output logic                              kb_nextdata_n,
  output logic [NUM_VOICES*INC_W-1:0]       voice_inc,
  output logic [NUM_VOICES-1:0]             voice_active,
  output logic [$clog2(NUM_VOICES+1)-1:0]   held_count,
  output logic                              steal
);

  localparam int unsigned PtrW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CntW = $clog2(NUM_VOICES+1);

  state_e                state_q, state_d;
  logic [7:0]            byte_q, byte_d;
  logic                  brk_q, brk_d, ext_q, ext_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [NUM_VOICES-1:0] act_q, act_d;
  logic [2:0]            idx_q [NUM_VOICES];
  logic [2:0]            idx_d [NUM_VOICES];
  logic [INC_W-1:0]      inc_q [NUM_VOICES];
  logic [INC_W-1:0]      inc_d [NUM_VOICES];
  logic                  steal_q, steal_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic            is_note;
  logic [2:0]      note_idx;
  logic            hit, free;
  logic [PtrW-1:0] hit_slot, free_slot;

  ps2_scan_decode u_decode (
    .code_i     (byte_q),
    .is_note_o  (is_note),
    .note_idx_o (note_idx)
  );

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    brk_d    = brk_q;
    ext_d    = ext_q;
    ptr_d    = ptr_q;
    act_d    = act_q;
    idx_d    = idx_q;
    inc_d    = inc_q;
    steal_d  = 1'b0;
    cnt_d    = '0;
    hit       = 1'b0;
    hit_slot  = '0;
    free      = 1'b0;
    free_slot = '0;

    // Descending scan so the lowest matching / free index wins.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (act_q[v] && (idx_q[v] == note_idx)) begin
        hit      = 1'b1;
        hit_slot = PtrW'(v);
      end
      if (!act_q[v]) begin
        free      = 1'b1;
        free_slot = PtrW'(v);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (kb_ready) begin
          byte_d  = kb_data;
          state_d = StAck;
        end
      end
      StAck: state_d = StProc;
      StProc: begin
        state_d = StIdle;
        if (byte_q == SC_BREAK) begin
          brk_d = 1'b1;
        end else if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else begin
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (!ext_q && is_note) begin
            if (brk_q) begin
              if (hit) begin
                act_d[hit_slot] = 1'b0;
                inc_d[hit_slot] = '0;
              end
            end else if (!hit) begin
              if (free) begin
                act_d[free_slot] = 1'b1;
                idx_d[free_slot] = note_idx;
                inc_d[free_slot] = INC_W'(PHASE_INC[note_idx]);
              end else begin
                idx_d[ptr_q] = note_idx;
                inc_d[ptr_q] = INC_W'(PHASE_INC[note_idx]);
                steal_d      = 1'b1;
                ptr_d        = (ptr_q == PtrW'(NUM_VOICES - 1)) ? '0 : ptr_q + PtrW'(1);
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (kb_overflow) begin
      act_d   = '0;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
      steal_d = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) inc_d[v] = '0;
    end

    for (int v = 0; v < NUM_VOICES; v++) cnt_d = cnt_d + CntW'(act_d[v]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      byte_q  <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      ptr_q   <= '0;
      act_q   <= '0;
      idx_q   <= '{default: '0};
      inc_q   <= '{default: '0};
      steal_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      ptr_q   <= ptr_d;
      act_q   <= act_d;
      idx_q   <= idx_d;
      inc_q   <= inc_d;
      steal_q <= steal_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by rst so a reset during ACK leaves the byte in the FIFO.
  assign kb_nextdata_n = !((state_q == StAck) && !rst);
  assign voice_active  = act_q;
  assign held_count    = cnt_q;
  assign steal         = steal_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign voice_inc[v*INC_W +: INC_W] = inc_q[v];
  end

endmodule

// File: tb/tb_ps2_voice_scheduler.sv
// Scoreboard bench: a FIFO model feeds bytes, a note-level reference model
// predicts the voice table per popped byte, and a monitor compares after each pop.
module tb_ps2_voice_scheduler;

  localparam int NV = 4;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    kb_data = 8'h00;
  logic          kb_ready = 1'b0;
  logic          kb_overflow = 1'b0;
  logic          kb_nextdata_n;
  logic [NV*IW-1:0] voice_inc;
  logic [NV-1:0] voice_active;
  logic [2:0]    held_count;
  logic          steal;

  ps2_voice_scheduler #(.NUM_VOICES(NV), .INC_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .kb_overflow   (kb_overflow),
    .kb_nextdata_n (kb_nextdata_n),
    .voice_inc     (voice_inc),
    .voice_active  (voice_active),
    .held_count    (held_count),
    .steal         (steal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NV*IW-1:0] inc;
    logic [NV-1:0]    act;
    int               cnt;
    bit               stl;
  } exp_t;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b1;
  bit         ovf_next = 1'b0;

  // Reference model: which note each slot holds (-1 = empty)
  int slot_note[NV];
  bit m_brk, m_ext;
  int m_ptr;
  int inc_tab[8] = '{714, 802, 900, 954, 1070, 1201, 1349, 1429};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int note_of(input logic [7:0] b);
    case (b)
      8'h1C: return 0;
      8'h1B: return 1;
      8'h23: return 2;
      8'h2B: return 3;
      8'h34: return 4;
      8'h33: return 5;
      8'h3B: return 6;
      8'h42: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic void model_clear();
    for (int v = 0; v < NV; v++) slot_note[v] = -1;
    m_brk = 1'b0;
    m_ext = 1'b0;
  endfunction

  function automatic bit model_byte(input logic [7:0] b);
    int n, s;
    bit stl = 1'b0;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      n = note_of(b);
      if (!m_ext && n >= 0) begin
        s = -1;
        for (int v = NV - 1; v >= 0; v--) if (slot_note[v] == n) s = v;
        if (m_brk) begin
          if (s >= 0) slot_note[s] = -1;
        end else if (s < 0) begin
          for (int v = NV - 1; v >= 0; v--) if (slot_note[v] < 0) s = v;
          if (s >= 0) slot_note[s] = n;
          else begin
            slot_note[m_ptr] = n;
            stl = 1'b1;
            m_ptr = (m_ptr + 1) % NV;
          end
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    return stl;
  endfunction

  function automatic exp_t snapshot(input bit stl);
    exp_t e;
    e.inc = '0;
    e.act = '0;
    e.cnt = 0;
    e.stl = stl;
    for (int v = 0; v < NV; v++) begin
      if (slot_note[v] >= 0) begin
        e.inc[v*IW +: IW] = 16'(inc_tab[slot_note[v]]);
        e.act[v] = 1'b1;
        e.cnt++;
      end
    end
    return e;
  endfunction

  task automatic refresh();
    kb_ready = (fifo_q.size() > 0);
    kb_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // FIFO model: pops on a sampled low strobe and predicts the resulting table.
  initial begin : fifo_proc
    bit p;
    bit stl;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      p = (kb_nextdata_n == 1'b0);
      @(posedge clk);
      #1;
      kb_overflow = 1'b0;
      if (p) begin
        checks++;
        if (fifo_q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty got pop want no_pop at %0t", $time);
        end else begin
          b   = fifo_q.pop_front();
          stl = model_byte(b);
          if (ovf_next) begin
            kb_overflow = 1'b1;
            model_clear();
            stl = 1'b0;
            ovf_next = 1'b0;
          end
          exp_q.push_back(snapshot(stl));
        end
      end
      refresh();
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && kb_nextdata_n == 1'b0) begin
        @(negedge clk);
        chk("pop_one_cycle", 64'(kb_nextdata_n), 64'd1);
        @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("expect_avail", 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("voice_inc", voice_inc, e.inc);
          chk("voice_active", 64'(voice_active), 64'(e.act));
          chk("held_count", 64'(held_count), 64'(e.cnt));
          chk("steal", 64'(steal), 64'(e.stl));
        end
      end
    end
  end

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (fifo_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    chk("drain_timeout", 64'(done), 64'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    bit found;
    logic [7:0] b;
    int r;
    model_clear();
    m_ptr = 0;
    refresh();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_nextdata_n", 64'(kb_nextdata_n), 64'd1);
    chk("rst_voice_inc", voice_inc, 64'd0);
    chk("rst_voice_active", 64'(voice_active), 64'd0);
    chk("rst_held_count", 64'(held_count), 64'd0);
    chk("rst_steal", 64'(steal), 64'd0);
    @(posedge clk);
    #1;

    push(8'h1C);
    drain();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    push(8'h1C); push(8'h1B); push(8'h23); push(8'h2B); push(8'h34);
    drain();
    push(8'hE0); push(8'h1C); push(8'hE0); push(8'hF0); push(8'h1C); push(8'h1C);
    drain();

    // Trim to two held keys, then overflow concurrent with a PROC make
    push(8'hF0); push(8'h23); push(8'hF0); push(8'h2B);
    drain();
    ovf_next = 1'b1;
    push(8'h3B);
    drain();
    push(8'h42); push(8'h33);
    drain();

    // Reset in the middle of ACK: byte must stay queued and be re-read
    mon_en = 1'b0;
    push(8'h1B);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (kb_nextdata_n == 1'b0) found = 1'b1;
    end
    chk("rst_ack_seen", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ack_nextdata_n", 64'(kb_nextdata_n), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    m_ptr = 0;
    chk("rst_ack_voice_inc", voice_inc, 64'd0);
    chk("rst_ack_active", 64'(voice_active), 64'd0);
    chk("rst_ack_count", 64'(held_count), 64'd0);
    chk("rst_ack_fifo_kept", 64'(fifo_q.size()), 64'd1);
    mon_en = 1'b1;
    drain();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        case ($urandom_range(0, 7))
          0: b = 8'h1C;
          1: b = 8'h1B;
          2: b = 8'h23;
          3: b = 8'h2B;
          4: b = 8'h34;
          5: b = 8'h33;
          6: b = 8'h3B;
          default: b = 8'h42;
        endcase
      end else if (r == 6) b = 8'hF0;
      else if (r == 7) b = 8'hE0;
      else if (r == 8) b = 8'h15;
      else b = 8'($urandom);
      push(b);
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
